gmm_cmac_acc: RTL

Pipelined complex multiply-accumulate engine for the GMM processor datapath: computes Σ a[n]·b[n] (optionally b conjugated) plus an optional complex initial value c over variable-length vectors delimited by a last flag. It generalises the fixed single-shot multiply-add into a streaming vector dot-product unit with saturation, overflow reporting, beat counting and valid/ready flow control. It sits between the operand fetch stage and the likelihood accumulation logic.

---
 rtl/gmm_cmac_acc.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/gmm_cmac_acc.sv
// Streaming complex multiply-accumulate: sums a[n]*b[n] (or a[n]*conj(b[n])) plus an
// optional seed over last-delimited vectors, with saturation, overflow and beat count.
module gmm_cmac_acc #(
  parameter int unsigned SIZEIN = 16,
  parameter int unsigned ACCW   = 40,
  parameter int unsigned CNTW   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic              s_last,
  input  logic              conj_b,
  input  logic              c_en,
  input  logic [SIZEIN-1:0] ar,
  input  logic [SIZEIN-1:0] ai,
  input  logic [SIZEIN-1:0] br,
  input  logic [SIZEIN-1:0] bi,
  input  logic [ACCW-1:0]   cr,
  input  logic [ACCW-1:0]   ci,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [ACCW-1:0]   m_r,
  output logic [ACCW-1:0]   m_i,
  output logic              m_ovf,
  output logic [CNTW-1:0]   m_count
);

  localparam int unsigned PW = 2 * SIZEIN + 1;
  localparam int unsigned SW = ACCW + 1;

  logic                     adv;
  logic                     first_q, first_d;
  logic                     s1_v_q, s1_v_d, s1_last_q, s1_last_d, s1_first_q, s1_first_d;
  logic                     s1_conj_q, s1_conj_d;
  logic signed [SIZEIN-1:0] s1_ar_q, s1_ar_d, s1_ai_q, s1_ai_d;
  logic signed [SIZEIN-1:0] s1_br_q, s1_br_d, s1_bi_q, s1_bi_d;
  logic signed [ACCW-1:0]   s1_sr_q, s1_sr_d, s1_si_q, s1_si_d;
  logic                     s2_v_q, s2_v_d, s2_last_q, s2_last_d, s2_first_q, s2_first_d;
  logic signed [PW-1:0]     s2_pr_q, s2_pr_d, s2_pi_q, s2_pi_d;
  logic signed [ACCW-1:0]   s2_sr_q, s2_sr_d, s2_si_q, s2_si_d;
  logic signed [ACCW-1:0]   acc_r_q, acc_r_d, acc_i_q, acc_i_d;
  logic                     ovf_q, ovf_d;
  logic [CNTW-1:0]          cnt_q, cnt_d;
  logic                     m_valid_q, m_valid_d, m_ovf_q, m_ovf_d;
  logic [ACCW-1:0]          m_r_q, m_r_d, m_i_q, m_i_d;
  logic [CNTW-1:0]          m_count_q, m_count_d;

  logic signed [PW-1:0]     ar_x, ai_x, br_x, bi_x, p_rr, p_ii, p_ri, p_ir;
  logic signed [ACCW-1:0]   base_r, base_i, sat_r, sat_i;
  logic signed [SW-1:0]     sum_r, sum_i;
  logic                     clip_r, clip_i, ovf_n;
  logic [CNTW-1:0]          cnt_n;

  assign adv     = ce & (~m_valid_q | m_ready);
  assign s_ready = adv;
  assign m_valid = m_valid_q;
  assign m_r     = m_r_q;
  assign m_i     = m_i_q;
  assign m_ovf   = m_ovf_q;
  assign m_count = m_count_q;

  // Partial products at full precision; the extra bit holds the add/sub carry.
  always_comb begin
    ar_x = PW'(s1_ar_q);
    ai_x = PW'(s1_ai_q);
    br_x = PW'(s1_br_q);
    bi_x = PW'(s1_bi_q);
    p_rr = ar_x * br_x;
    p_ii = ai_x * bi_x;
    p_ri = ar_x * bi_x;
    p_ir = ai_x * br_x;
  end

  // Accumulate at ACCW+1 bits, then clamp back to ACCW.
  always_comb begin
    base_r = s2_first_q ? s2_sr_q : acc_r_q;
    base_i = s2_first_q ? s2_si_q : acc_i_q;
    sum_r  = SW'(base_r) + SW'(s2_pr_q);
    sum_i  = SW'(base_i) + SW'(s2_pi_q);
    clip_r = sum_r[ACCW] ^ sum_r[ACCW-1];
    clip_i = sum_i[ACCW] ^ sum_i[ACCW-1];
    sat_r  = clip_r ? {sum_r[ACCW], {(ACCW-1){~sum_r[ACCW]}}} : sum_r[ACCW-1:0];
    sat_i  = clip_i ? {sum_i[ACCW], {(ACCW-1){~sum_i[ACCW]}}} : sum_i[ACCW-1:0];
    ovf_n  = (~s2_first_q & ovf_q) | clip_r | clip_i;
    cnt_n  = s2_first_q ? CNTW'(1) : ((&cnt_q) ? cnt_q : cnt_q + CNTW'(1));
  end

  always_comb begin
    first_d    = first_q;
    s1_v_d     = s1_v_q;     s1_last_d = s1_last_q; s1_first_d = s1_first_q;
    s1_conj_d  = s1_conj_q;
    s1_ar_d    = s1_ar_q;    s1_ai_d   = s1_ai_q;   s1_br_d    = s1_br_q;  s1_bi_d = s1_bi_q;
    s1_sr_d    = s1_sr_q;    s1_si_d   = s1_si_q;
    s2_v_d     = s2_v_q;     s2_last_d = s2_last_q; s2_first_d = s2_first_q;
    s2_pr_d    = s2_pr_q;    s2_pi_d   = s2_pi_q;   s2_sr_d    = s2_sr_q;  s2_si_d = s2_si_q;
    acc_r_d    = acc_r_q;    acc_i_d   = acc_i_q;   ovf_d      = ovf_q;    cnt_d   = cnt_q;
    m_valid_d  = m_valid_q;  m_r_d     = m_r_q;     m_i_d      = m_i_q;
    m_ovf_d    = m_ovf_q;    m_count_d = m_count_q;
    if (adv) begin
      s1_v_d = s_valid;
      if (s_valid) begin
        s1_last_d  = s_last;
        s1_first_d = first_q;
        s1_conj_d  = conj_b;
        s1_ar_d    = ar;
        s1_ai_d    = ai;
        s1_br_d    = br;
        s1_bi_d    = bi;
        s1_sr_d    = (c_en & first_q) ? cr : '0;
        s1_si_d    = (c_en & first_q) ? ci : '0;
        first_d    = s_last;
      end
      s2_v_d = s1_v_q;
      if (s1_v_q) begin
        s2_last_d  = s1_last_q;
        s2_first_d = s1_first_q;
        s2_pr_d    = s1_conj_q ? p_rr + p_ii : p_rr - p_ii;
        s2_pi_d    = s1_conj_q ? p_ir - p_ri : p_ri + p_ir;
        s2_sr_d    = s1_sr_q;
        s2_si_d    = s1_si_q;
      end
      m_valid_d = 1'b0;
      if (s2_v_q) begin
        acc_r_d = sat_r;
        acc_i_d = sat_i;
        ovf_d   = ovf_n;
        cnt_d   = cnt_n;
        if (s2_last_q) begin
          m_valid_d = 1'b1;
          m_r_d     = sat_r;
          m_i_d     = sat_i;
          m_ovf_d   = ovf_n;
          m_count_d = cnt_n;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      first_q    <= 1'b1;
      s1_v_q     <= 1'b0; s1_last_q <= 1'b0; s1_first_q <= 1'b0; s1_conj_q <= 1'b0;
      s1_ar_q    <= '0;   s1_ai_q   <= '0;   s1_br_q    <= '0;   s1_bi_q   <= '0;
      s1_sr_q    <= '0;   s1_si_q   <= '0;
      s2_v_q     <= 1'b0; s2_last_q <= 1'b0; s2_first_q <= 1'b0;
      s2_pr_q    <= '0;   s2_pi_q   <= '0;   s2_sr_q    <= '0;   s2_si_q   <= '0;
      acc_r_q    <= '0;   acc_i_q   <= '0;   ovf_q      <= 1'b0; cnt_q     <= '0;
      m_valid_q  <= 1'b0; m_r_q     <= '0;   m_i_q      <= '0;
      m_ovf_q    <= 1'b0; m_count_q <= '0;
    end else begin
      first_q    <= first_d;
      s1_v_q     <= s1_v_d;  s1_last_q <= s1_last_d; s1_first_q <= s1_first_d;
      s1_conj_q  <= s1_conj_d;
      s1_ar_q    <= s1_ar_d; s1_ai_q   <= s1_ai_d;   s1_br_q    <= s1_br_d;  s1_bi_q <= s1_bi_d;
      s1_sr_q    <= s1_sr_d; s1_si_q   <= s1_si_d;
      s2_v_q     <= s2_v_d;  s2_last_q <= s2_last_d; s2_first_q <= s2_first_d;
      s2_pr_q    <= s2_pr_d; s2_pi_q   <= s2_pi_d;   s2_sr_q    <= s2_sr_d;  s2_si_q <= s2_si_d;
      acc_r_q    <= acc_r_d; acc_i_q   <= acc_i_d;   ovf_q      <= ovf_d;    cnt_q   <= cnt_d;
      m_valid_q  <= m_valid_d; m_r_q   <= m_r_d;     m_i_q      <= m_i_d;
      m_ovf_q    <= m_ovf_d; m_count_q <= m_count_d;
    end
  end

endmodule
